mem_access_seq: RTL
===================

Name: mem_access_seq

Overview:
- Upstream sequencer for the MAR/MDR memory controller.
- Accepts one read or write request at a time from the CPU control unit, then runs the LC-3 memory handshake: it drives the address and write data onto the CPU bus, pulses ld_mar/ld_mdr, holds mio_en/rw until the memory reports ready, and captures read data from the MDR.
- Returns a single-cycle response with read data or a timeout error.

Parameters:
- TIMEOUT_CYCLES, 16, max cycles spent in a wait state before aborting with an error; 0 disables the timeout.
- DW, 16, data and address width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_write  in  1  1=write, 0=read.
- req_addr  in  DW  target address.
- req_wdata  in  DW  write data.
- req_ready  out  1  high only in IDLE; request accepted when req_valid & req_ready.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DW  read data; 0 for writes and on error.
- resp_err  out  1  timeout flag, qualified by resp_valid.
- busy  out  1  = ~req_ready.
- bus_gate  out  1  sequencer drives bus_drive onto the CPU bus this cycle.
- bus_drive  out  DW  value for the CPU bus; 0 when bus_gate=0.
- ld_mar  out  1  load MAR from bus.
- ld_mdr  out  1  load MDR.
- mio_en  out  1  memory operation enable.
- rw  out  1  1=write, 0=read; 0 unless in WR_WAIT.
- mdr_in  in  DW  memory controller MDR output.
- mem_ready  in  1  memory op complete.

Behaviour:
- Reset: state=IDLE, counter=0, all captured registers=0. Outputs after reset: req_ready=1; every other output 0. Reset mid-operation abandons the access: no resp_valid, and ld_*/mio_en drop on the next edge.
- Accept: in IDLE, req_valid=1 registers addr_q/wdata_q/write_q, then goes to LD_MAR. req_valid is ignored outside IDLE.
- LD_MAR (1 cycle): bus_gate=1, bus_drive=addr_q, ld_mar=1. Next state is WR_MDR if write_q, else RD_WAIT.
- WR_MDR (1 cycle): bus_gate=1, bus_drive=wdata_q, ld_mdr=1, mio_en=0 (MDR takes bus data). Next WR_WAIT.
- WR_WAIT: mio_en=1, rw=1, counter increments each cycle. Exits:
  - mem_ready=1: go to DONE, err_q=0.
  - otherwise, counter reaches TIMEOUT_CYCLES-1 with mem_ready=0: err_q=1, go to DONE.
- RD_WAIT: mio_en=1, rw=0, and ld_mdr=mem_ready (combinational, so MDR loads memory data in the ready cycle). Exits:
  - mem_ready=1: go to RD_CAP.
  - timeout (same rule as WR_WAIT): err_q=1, go to DONE, ld_mdr not asserted.
- RD_CAP (1 cycle): rdata_q <= mdr_in. Next DONE.
- DONE (1 cycle): resp_valid=1, resp_rdata=rdata_q (read, no error) else 0, resp_err=err_q. Then: counter=0, rdata_q=0, err_q=0, next IDLE.
- Mutual exclusion: bus_gate and mio_en are never both high. rw=1 only with mio_en=1.
- Latency with mem_ready on the first wait cycle: accept at cycle T, resp_valid at T+4 for both reads and writes. Each extra wait cycle adds 1.
- Back-to-back: the next request is accepted in the cycle after DONE (IDLE). Minimum period is 5 cycles.
- mem_ready outside a wait state is ignored.
- TIMEOUT_CYCLES=0: wait states are unbounded and resp_err is never set.
- Counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1. No wrap is possible because the timeout terminates the count.

Test Plan:
- Reset check: assert rst for 2 cycles, then release -> req_ready=1, all other outputs 0. Repeat rst with req_valid=1 held -> still no acceptance during reset.
- Write 0xBEEF to 0x3000, mem_ready high on first WR_WAIT cycle:
  - Cycle T+1: bus_drive=0x3000 with ld_mar.
  - Cycle T+2: bus_drive=0xBEEF with ld_mdr and mio_en=0.
  - Cycle T+3: mio_en=1, rw=1.
  - Cycle T+4: resp_valid=1, resp_err=0, resp_rdata=0.
- Read 0x3001 with mem_ready delayed 3 cycles and mdr_in=0x1234 after the load:
  - ld_mdr pulses only in the ready cycle.
  - resp_valid at T+7 with resp_rdata=0x1234.
- Timeout: read with mem_ready held 0, TIMEOUT_CYCLES=16 -> mio_en high exactly 16 cycles, then resp_valid=1, resp_err=1, resp_rdata=0, and ld_mdr never asserted.
- Reset mid-op: assert rst during WR_WAIT -> next cycle mio_en=0, rw=0, req_ready=1, no resp_valid. A following read completes normally.
- Back-to-back write then read of 0x4000, with req_valid held high -> second accept in the cycle after the first resp_valid. Read returns the written value via a memory model, and bus_gate & mio_en is never 1 in the same cycle.

Source files
------------

// File: rtl/mem_access_seq_if.sv
// Request/response and LC-3 memory handshake bundle for mem_access_seq.
// Latency: none, this is wiring only.
// Backpressure: req_ready from the sequencer; memory side stalls via mem_ready.
interface mem_access_seq_if #(
    parameter int DW = 16
);
    // CPU control unit request side
    logic          req_valid;
    logic          req_write;
    logic [DW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          req_ready;

    // single-cycle completion
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;
    logic          busy;

    // CPU bus and MAR/MDR controller handshake
    logic          bus_gate;
    logic [DW-1:0] bus_drive;
    logic          ld_mar;
    logic          ld_mdr;
    logic          mio_en;
    logic          rw;
    logic [DW-1:0] mdr_in;
    logic          mem_ready;

    // master: the sequencer, which owns the CPU bus and the memory handshake
    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        input  mdr_in, mem_ready,
        output req_ready, resp_valid, resp_rdata, resp_err, busy,
        output bus_gate, bus_drive, ld_mar, ld_mdr, mio_en, rw
    );

    // slave: the control unit plus memory controller around the sequencer
    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        output mdr_in, mem_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy,
        input  bus_gate, bus_drive, ld_mar, ld_mdr, mio_en, rw
    );
endinterface

// File: rtl/mem_access_seq.sv
// Sequences one CPU read/write through the LC-3 MAR/MDR memory handshake.
// Latency: accept to resp_valid is 4 cycles with mem_ready on the first wait cycle, +1 per extra wait.
// Backpressure: one access in flight; req_ready only in IDLE, waits bounded by TIMEOUT_CYCLES (0 = unbounded).
module mem_access_seq #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int DW             = 16
) (
    input  logic              clk,
    input  logic              rst,
    mem_access_seq_if.master  mab
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LD_MAR  = 3'd1;
    localparam logic [2:0] WR_MDR  = 3'd2;
    localparam logic [2:0] WR_WAIT = 3'd3;
    localparam logic [2:0] RD_WAIT = 3'd4;
    localparam logic [2:0] RD_CAP  = 3'd5;
    localparam logic [2:0] DONE    = 3'd6;

    // The counter only has to reach TIMEOUT_CYCLES-1; keep at least one bit
    // so the disabled configuration still elaborates cleanly.
    localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);
    localparam int CW     = TMO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = TMO_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;

    // Captured request, held stable for the whole access.
    typedef struct packed {
        logic          write;
        logic [DW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    logic [2:0]    state_q;
    logic [2:0]    state_d;
    req_t          req_q;
    logic [CW-1:0] cnt_q;
    logic          err_q;
    logic [DW-1:0] rdata_q;

    logic          in_wait;
    logic          tmo_hit;
    logic          accept;

    assign accept  = (state_q == IDLE) && mab.req_valid;
    assign in_wait = (state_q == WR_WAIT) || (state_q == RD_WAIT);
    // Abort only when memory has not answered in the last allowed cycle;
    // a ready in that same cycle still wins.
    assign tmo_hit = TMO_EN && in_wait && !mab.mem_ready && (cnt_q == CNT_LAST);

    // Next-state selection for the handshake sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (mab.req_valid) begin
                    state_d = LD_MAR;
                end
            end
            LD_MAR: begin
                state_d = req_q.write ? WR_MDR : RD_WAIT;
            end
            WR_MDR: begin
                state_d = WR_WAIT;
            end
            WR_WAIT: begin
                if (mab.mem_ready || tmo_hit) begin
                    state_d = DONE;
                end
            end
            RD_WAIT: begin
                if (mab.mem_ready) begin
                    state_d = RD_CAP;
                end else if (tmo_hit) begin
                    state_d = DONE;
                end
            end
            RD_CAP: begin
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request capture, wait counter, error flag and read data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        req_q.write <= mab.req_write;
                        req_q.addr  <= mab.req_addr;
                        req_q.wdata <= mab.req_wdata;
                    end
                end
                WR_WAIT, RD_WAIT: begin
                    if (mab.mem_ready) begin
                        err_q <= 1'b0;
                    end else if (tmo_hit) begin
                        err_q <= 1'b1;
                    end
                    // Not advanced when disabled so the narrow counter never wraps.
                    if (TMO_EN) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RD_CAP: begin
                    // MDR was loaded from memory on the ready edge.
                    rdata_q <= mab.mdr_in;
                end
                DONE: begin
                    cnt_q   <= '0;
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode: bus driving phases never overlap the memory enable phase.
    always_comb begin
        mab.req_ready  = 1'b0;
        mab.resp_valid = 1'b0;
        mab.resp_rdata = '0;
        mab.resp_err   = 1'b0;
        mab.bus_gate   = 1'b0;
        mab.bus_drive  = '0;
        mab.ld_mar     = 1'b0;
        mab.ld_mdr     = 1'b0;
        mab.mio_en     = 1'b0;
        mab.rw         = 1'b0;
        case (state_q)
            IDLE: begin
                mab.req_ready = 1'b1;
            end
            LD_MAR: begin
                mab.bus_gate  = 1'b1;
                mab.bus_drive = req_q.addr;
                mab.ld_mar    = 1'b1;
            end
            WR_MDR: begin
                // mio_en low so the MDR takes the bus value, not memory.
                mab.bus_gate  = 1'b1;
                mab.bus_drive = req_q.wdata;
                mab.ld_mdr    = 1'b1;
            end
            WR_WAIT: begin
                mab.mio_en = 1'b1;
                mab.rw     = 1'b1;
            end
            RD_WAIT: begin
                // Load MDR from memory exactly in the ready cycle; a timeout never loads.
                mab.mio_en = 1'b1;
                mab.ld_mdr = mab.mem_ready;
            end
            DONE: begin
                mab.resp_valid = 1'b1;
                mab.resp_err   = err_q;
                mab.resp_rdata = (!req_q.write && !err_q) ? rdata_q : '0;
            end
            default: begin
            end
        endcase
    end

    // busy is simply the complement of ready.
    always_comb begin
        mab.busy = ~mab.req_ready;
    end

endmodule
